muldiv_issue_ctrl: RTL and testbench

MULDIV_ISSUE_CTRL -- requirements
Module: muldiv_issue_ctrl

---
 rtl/muldiv_issue_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller between the core and the shared multiplier/divider units.
// Latches one M-extension op, starts the matching unit (or resolves divide
// special cases locally), waits for its result and holds it until taken.
// Latency counts the accept cycle and the first resp_valid cycle, so a
// locally resolved op shows resp_valid on the cycle right after the accept edge.
module muldiv_issue_ctrl #(
  parameter bit BYPASS_SPECIAL = 1'b1,
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            mul_start,
  output logic [1:0]      mul_op,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_result,
  output logic            div_start,
  output logic [1:0]      div_op,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_WAIT = 3'd2,
    DONE     = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic            drain_div_q;
  logic            drain_div_d;

  logic            req_ready_d;
  logic            busy_d;
  logic            resp_valid_d;
  logic [XLEN-1:0] resp_data_d;
  logic [XLEN-1:0] op_a_d;
  logic [XLEN-1:0] op_b_d;
  logic            mul_start_d;
  logic [1:0]      mul_op_d;
  logic            div_start_d;
  logic [1:0]      div_op_d;

  logic            div_by_zero;
  logic            div_overflow;
  logic            div_special;
  logic [XLEN-1:0] special_result;
  logic            drain_done;

  // Divide special cases, judged on the raw request operands
  always_comb begin
    div_by_zero  = (rs2 == '0);
    div_overflow = ~funct3[0] && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    div_special  = funct3[2] && (div_by_zero || div_overflow);
    if (div_by_zero) begin
      special_result = funct3[1] ? rs1 : ALL_ONES;
    end else begin
      special_result = funct3[1] ? '0 : INT_MIN;
    end
  end

  // A drained op only completes on the ready of the unit it was sent to
  always_comb begin
    drain_done = drain_div_q ? div_ready : mul_ready;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    drain_div_d  = drain_div_q;
    resp_data_d  = resp_data;
    op_a_d       = op_a;
    op_b_d       = op_b;
    mul_op_d     = mul_op;
    div_op_d     = div_op;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // flush outranks a request; unit readies are stale here
        if (!flush && req_valid) begin
          op_a_d = rs1;
          op_b_d = rs2;
          if (!funct3[2]) begin
            mul_op_d    = funct3[1:0];
            mul_start_d = 1'b1;
            state_d     = MUL_WAIT;
          end else begin
            div_op_d = funct3[1:0];
            if (BYPASS_SPECIAL && div_special) begin
              resp_data_d = special_result;
              state_d     = DONE;
            end else begin
              div_start_d = 1'b1;
              state_d     = DIV_WAIT;
            end
          end
        end
      end

      MUL_WAIT: begin
        if (mul_ready) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            resp_data_d = mul_result;
            state_d     = DONE;
          end
        end else if (flush) begin
          drain_div_d = 1'b0;
          state_d     = DRAIN;
        end
      end

      DIV_WAIT: begin
        if (div_ready) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            resp_data_d = div_result;
            state_d     = DONE;
          end
        end else if (flush) begin
          drain_div_d = 1'b1;
          state_d     = DRAIN;
        end
      end

      DONE: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      drain_div_q <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      op_a        <= '0;
      op_b        <= '0;
      mul_start   <= 1'b0;
      mul_op      <= '0;
      div_start   <= 1'b0;
      div_op      <= '0;
    end else begin
      state_q     <= state_d;
      drain_div_q <= drain_div_d;
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
      op_a        <= op_a_d;
      op_b        <= op_b_d;
      mul_start   <= mul_start_d;
      mul_op      <= mul_op_d;
      div_start   <= div_start_d;
      div_op      <= div_op_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: the bench plays the core and both units.
// Expected results come from RISC-V M-extension arithmetic; expected timing
// comes from the transaction schedule each task sets up.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic        mul_ready;
  logic [31:0] mul_result;
  logic        div_start;
  logic [1:0]  div_op;
  logic        div_ready;
  logic [31:0] div_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int mul_starts = 0;
  int div_starts = 0;

  logic [2:0]  rf3;
  logic [31:0] ra;
  logic [31:0] rb;
  int          rsel;
  int          rkind;

  always #5 clk = ~clk;

  muldiv_issue_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_start  (mul_start),
    .mul_op     (mul_op),
    .mul_ready  (mul_ready),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_op     (div_op),
    .div_ready  (div_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  // Count start pulses seen by the units
  always @(posedge clk) begin
    if (mul_start) mul_starts++;
    if (div_start) div_starts++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic [63:0]        up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f3)
      3'd0: return a * b;
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic quiet_inputs();
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    mul_ready  = 1'b0;
    div_ready  = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_req_ready"},  32'(req_ready),  32'd1);
    chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({pfx, "_resp_data"},  resp_data,       32'd0);
    chk({pfx, "_op_a"},       op_a,            32'd0);
    chk({pfx, "_op_b"},       op_b,            32'd0);
    chk({pfx, "_mul_op"},     32'(mul_op),     32'd0);
    chk({pfx, "_div_op"},     32'(div_op),     32'd0);
    chk({pfx, "_mul_start"},  32'(mul_start),  32'd0);
    chk({pfx, "_div_start"},  32'(div_start),  32'd0);
    chk({pfx, "_busy"},       32'(busy),       32'd0);
  endtask

  // Present one request for one cycle; returns in the cycle after the accept edge
  task automatic accept_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    @(negedge clk);
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    rs1       = $urandom;
    rs2       = $urandom;
  endtask

  task automatic check_started(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    chk("start_excl", 32'(mul_start & div_start), 32'd0);
    chk("op_a", op_a, a);
    chk("op_b", op_b, b);
    chk("busy_start", 32'(busy), 32'd1);
    if (!f3[2]) begin
      chk("mul_start", 32'(mul_start), 32'd1);
      chk("mul_op", 32'(mul_op), 32'(f3[1:0]));
    end else begin
      chk("div_start", 32'(div_start), 32'd1);
      chk("div_op", 32'(div_op), 32'(f3[1:0]));
    end
  endtask

  // Full op: unit answers lat cycles after its start pulse, core stalls hold cycles
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input bit end_flush);
    logic [31:0] exp;
    bit          spec;
    int          m0;
    int          d0;
    exp  = ref_result(f3, a, b);
    spec = is_special(f3, a, b);
    m0   = mul_starts;
    d0   = div_starts;
    accept_op(f3, a, b);
    if (spec) begin
      chk("byp_no_start", {30'd0, mul_start, div_start}, 32'd0);
    end else begin
      check_started(f3, a, b);
      for (int i = 1; i <= lat; i++) begin
        if (!f3[2]) begin
          div_ready  = 1'($urandom_range(0, 1));
          div_result = $urandom;
        end else begin
          mul_ready  = 1'($urandom_range(0, 1));
          mul_result = $urandom;
        end
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_valid", 32'(resp_valid), 32'd0);
      end
      mul_ready = !f3[2];
      div_ready = f3[2];
      if (!f3[2]) mul_result = exp; else div_result = exp;
      @(negedge clk);
      mul_ready  = 1'b0;
      div_ready  = 1'b0;
      mul_result = $urandom;
      div_result = $urandom;
    end
    chk("done_valid", 32'(resp_valid), 32'd1);
    chk("done_data", resp_data, exp);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      funct3     = 3'($urandom);
      rs1        = $urandom;
      rs2        = $urandom;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, exp);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_no_start", {30'd0, mul_start, div_start}, 32'd0);
    end
    req_valid = 1'b1;
    funct3    = 3'($urandom);
    rs1       = $urandom;
    rs2       = $urandom;
    if (end_flush) flush = 1'b1; else resp_ready = 1'b1;
    @(negedge clk);
    quiet_inputs();
    chk("ret_req_ready", 32'(req_ready), 32'd1);
    chk("ret_no_valid", 32'(resp_valid), 32'd0);
    chk("ret_busy", 32'(busy), 32'd0);
    chk("ret_no_start", {30'd0, mul_start, div_start}, 32'd0);
    chk("mul_pulses", 32'(mul_starts - m0), 32'(!f3[2]));
    chk("div_pulses", 32'(div_starts - d0), 32'(f3[2] && !spec));
  endtask

  // Flush in cycle fl_c (start pulse is cycle 1), unit answers in cycle rd_c >= fl_c
  task automatic flush_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int fl_c, input int rd_c);
    accept_op(f3, a, b);
    check_started(f3, a, b);
    for (int c = 1; c <= rd_c; c++) begin
      flush = (c == fl_c);
      if (!f3[2]) begin
        mul_ready  = (c == rd_c);
        mul_result = $urandom;
        div_ready  = 1'($urandom_range(0, 1));
        div_result = $urandom;
      end else begin
        div_ready  = (c == rd_c);
        div_result = $urandom;
        mul_ready  = 1'($urandom_range(0, 1));
        mul_result = $urandom;
      end
      @(negedge clk);
      quiet_inputs();
      chk("fl_no_valid", 32'(resp_valid), 32'd0);
      if (c < rd_c) begin
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_req_ready", 32'(req_ready), 32'd0);
      end else begin
        chk("fl_idle_ready", 32'(req_ready), 32'd1);
        chk("fl_idle_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clk);
    chk("fl_after_valid", 32'(resp_valid), 32'd0);
    chk("fl_after_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    funct3     = 3'd0;
    rs1        = 32'd0;
    rs2        = 32'd0;
    mul_result = 32'd0;
    div_result = 32'd0;
    quiet_inputs();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // 7*6 with a three-cycle multiplier, then a long stall in DONE
    run_op(3'd0, 32'd7, 32'd6, 3, 2, 1'b0);
    run_op(3'd1, 32'hFFFF_FFF9, 32'd6, 2, 5, 1'b0);

    // divide-by-zero and overflow resolved without the divider
    run_op(3'd5, 32'd100, 32'd0, 0, 1, 1'b0);
    run_op(3'd7, 32'd100, 32'd0, 0, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

    // flush while dividing: drain until the divider answers
    flush_op(3'd4, 32'd1000, 32'd7, 3, 6);
    // flush coinciding with the unit's ready
    flush_op(3'd0, 32'd5, 32'd9, 2, 2);
    // flush in DONE
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1'b1);

    // flush beats a request in IDLE
    req_valid = 1'b1;
    flush     = 1'b1;
    funct3    = 3'd0;
    rs1       = 32'd3;
    rs2       = 32'd4;
    @(negedge clk);
    quiet_inputs();
    chk("idle_flush_ready", 32'(req_ready), 32'd1);
    chk("idle_flush_busy", 32'(busy), 32'd0);
    chk("idle_flush_start", {30'd0, mul_start, div_start}, 32'd0);

    // asynchronous reset in DIV_WAIT, then a stale divider answer
    accept_op(3'd5, 32'd1000, 32'd7);
    check_started(3'd5, 32'd1000, 32'd7);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    div_ready  = 1'b1;
    div_result = 32'h1234_5678;
    @(negedge clk);
    quiet_inputs();
    chk("stale_no_valid", 32'(resp_valid), 32'd0);
    chk("stale_req_ready", 32'(req_ready), 32'd1);
    chk("stale_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("stale_no_valid2", 32'(resp_valid), 32'd0);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      rf3  = 3'($urandom);
      rsel = $urandom_range(0, 7);
      ra   = $urandom;
      rb   = $urandom;
      if (rsel == 0) rb = 32'd0;
      if (rsel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (rsel == 2) begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
      rkind = $urandom_range(0, 3);
      if (rkind == 3) begin
        if (is_special(rf3, ra, rb)) rb = 32'd3;
        begin
          int fc;
          fc = $urandom_range(1, 4);
          flush_op(rf3, ra, rb, fc, fc + $urandom_range(0, 3));
        end
      end else begin
        run_op(rf3, ra, rb, $urandom_range(1, 5), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
